// File: rtl/pc_pkg.sv
// Shared types and op encodings for the program-counter unit.
package pc_pkg;

   typedef logic [2:0] op_t;

   localparam op_t OP_SEQ  = 3'd0;
   localparam op_t OP_BR   = 3'd1;
   localparam op_t OP_JMP  = 3'd2;
   localparam op_t OP_CALL = 3'd3;
   localparam op_t OP_RET  = 3'd4;

endpackage

// File: rtl/pc_unit_if.sv
// Control-side bundle for pc_unit: per-cycle op request and registered PC/RAS status.
interface pc_unit_if
   import pc_pkg::*;
#(
   parameter int PC_W  = 11,
   parameter int OFF_W = 8
);

   logic             stall;
   op_t              op;
   logic [OFF_W-1:0] offset;
   logic [PC_W-1:0]  target;
   logic [PC_W-1:0]  pc;
   logic             ras_empty;
   logic             ras_full;
   logic             ras_ovf;
   logic             ras_unf;

   modport master (
      output stall, op, offset, target,
      input  pc, ras_empty, ras_full, ras_ovf, ras_unf
   );

   modport slave (
      input  stall, op, offset, target,
      output pc, ras_empty, ras_full, ras_ovf, ras_unf
   );

endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full silently drops the oldest entry.
module pc_ras #(
   parameter int PC_W      = 11,
   parameter int RAS_DEPTH = 4
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            i_push,
   input  logic            i_pop,
   input  logic [PC_W-1:0] i_data,
   output logic [PC_W-1:0] o_data,
   output logic            o_empty,
   output logic            o_full
);

   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PC_W-1:0]  r_mem [RAS_DEPTH];
   logic [PTR_W-1:0] r_top;
   logic [CNT_W-1:0] r_cnt;
   logic [PTR_W-1:0] w_top_inc;
   logic [PTR_W-1:0] w_top_dec;
   logic             w_do_pop;

   assign w_top_inc = r_top + PTR_W'(1);
   assign w_top_dec = r_top - PTR_W'(1);
   assign w_do_pop  = i_pop && !o_empty;

   assign o_data  = r_mem[r_top];
   assign o_empty = (r_cnt == '0);
   assign o_full  = (r_cnt == CNT_W'(RAS_DEPTH));

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_top <= '0;
         r_cnt <= '0;
      end else if (i_push) begin
         r_top <= w_top_inc;
         if (!o_full)
            r_cnt <= r_cnt + CNT_W'(1);
      end else if (w_do_pop) begin
         r_top <= w_top_dec;
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   // When full, the slot after top holds the oldest entry, so it is overwritten.
   always_ff @(posedge clk) begin
      if (reset_n && i_push)
         r_mem[w_top_inc] <= i_data;
   end

endmodule

// File: rtl/pc_unit.sv
// Program counter with branch/jump/call/return next-PC selection, stall and RAS.
module pc_unit
   import pc_pkg::*;
#(
   parameter int              PC_W      = 11,
   parameter int              OFF_W     = 8,
   parameter int              RAS_DEPTH = 4,
   parameter logic [PC_W-1:0] RESET_PC  = '0
) (
   input  logic clk,
   input  logic reset_n,
   pc_unit_if.slave bus
);

   logic [PC_W-1:0] r_pc;
   logic            r_ovf;
   logic            r_unf;

   logic [PC_W-1:0] w_off;
   logic [PC_W-1:0] w_pc_inc;
   logic [PC_W-1:0] w_pc_br;
   logic [PC_W-1:0] w_pc_nxt;
   logic [PC_W-1:0] w_ras_data;
   logic            w_ras_empty;
   logic            w_ras_full;
   logic            w_go;
   logic            w_is_br;
   logic            w_is_jmp;
   logic            w_is_call;
   logic            w_is_ret;
   logic            w_is_seq;

   assign w_go      = !bus.stall;
   assign w_is_br   = w_go && (bus.op == OP_BR);
   assign w_is_jmp  = w_go && (bus.op == OP_JMP);
   assign w_is_call = w_go && (bus.op == OP_CALL);
   assign w_is_ret  = w_go && (bus.op == OP_RET);
   assign w_is_seq  = w_go && !(w_is_br || w_is_jmp || w_is_call || w_is_ret);

   assign w_off    = PC_W'($signed(bus.offset));
   assign w_pc_inc = r_pc + PC_W'(1);
   assign w_pc_br  = r_pc + w_off;

   pc_ras #(
      .PC_W      (PC_W),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk     (clk),
      .reset_n (reset_n),
      .i_push  (w_is_call),
      .i_pop   (w_is_ret),
      .i_data  (w_pc_inc),
      .o_data  (w_ras_data),
      .o_empty (w_ras_empty),
      .o_full  (w_ras_full)
   );

   always_comb begin
      w_pc_nxt = r_pc;
      unique case (1'b1)
         w_is_seq:  w_pc_nxt = w_pc_inc;
         w_is_br:   w_pc_nxt = w_pc_br;
         w_is_jmp:  w_pc_nxt = bus.target;
         w_is_call: w_pc_nxt = bus.target;
         w_is_ret:  w_pc_nxt = w_ras_empty ? w_pc_inc : w_ras_data;
         default:   w_pc_nxt = r_pc;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_pc  <= RESET_PC;
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
      end else begin
         r_pc <= w_pc_nxt;
         if (w_is_call && w_ras_full)
            r_ovf <= 1'b1;
         if (w_is_ret && w_ras_empty)
            r_unf <= 1'b1;
      end
   end

   assign bus.pc        = r_pc;
   assign bus.ras_empty = w_ras_empty;
   assign bus.ras_full  = w_ras_full;
   assign bus.ras_ovf   = r_ovf;
   assign bus.ras_unf   = r_unf;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios plus random ops against a queue-based model.
module tb_pc_unit;
   import pc_pkg::*;

   localparam int PC_W  = 11;
   localparam int OFF_W = 8;
   localparam int DEPTH = 4;
   localparam int MODN  = 1 << PC_W;

   logic clk = 1'b0;
   logic reset_n;

   pc_unit_if #(.PC_W(PC_W), .OFF_W(OFF_W)) bus ();

   pc_unit #(
      .PC_W      (PC_W),
      .OFF_W     (OFF_W),
      .RAS_DEPTH (DEPTH),
      .RESET_PC  ('0)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // Reference model: PC as integer, RAS as a queue with newest at back.
   int m_pc = 0;
   int m_ras[$];
   bit m_ovf = 0;
   bit m_unf = 0;
   bit chk_en = 0;

   // Literal expectations posted by the stimulus, checked by the compare process.
   int lit_seq = 0;
   int lit_pc;
   int lit_fmask;
   int lit_flags;
   string lit_name;

   always @(posedge clk) begin
      int ofs;
      if (!reset_n) begin
         m_pc = 0;
         m_ras.delete();
         m_ovf = 0;
         m_unf = 0;
      end else if (!bus.stall) begin
         case (bus.op)
            OP_BR: begin
               ofs = int'(bus.offset);
               if (ofs >= (1 << (OFF_W - 1)))
                  ofs = ofs - (1 << OFF_W);
               m_pc = ((m_pc + ofs) % MODN + MODN) % MODN;
            end
            OP_JMP: m_pc = int'(bus.target);
            OP_CALL: begin
               if (m_ras.size() == DEPTH) begin
                  void'(m_ras.pop_front());
                  m_ovf = 1;
               end
               m_ras.push_back((m_pc + 1) % MODN);
               m_pc = int'(bus.target);
            end
            OP_RET: begin
               if (m_ras.size() > 0)
                  m_pc = m_ras.pop_back();
               else begin
                  m_pc = (m_pc + 1) % MODN;
                  m_unf = 1;
               end
            end
            default: m_pc = (m_pc + 1) % MODN;
         endcase
      end
   end

   int last_seq = 0;

   always @(negedge clk) begin
      int fl;
      if (chk_en) begin
         fl = {28'd0, bus.ras_empty, bus.ras_full, bus.ras_ovf, bus.ras_unf};
         n_chk++;
         if (int'(bus.pc) != m_pc) begin
            n_err++;
            $display("FAIL pc: got %03h want %03h", bus.pc, m_pc);
         end
         n_chk++;
         if (bus.ras_empty != (m_ras.size() == 0)) begin
            n_err++;
            $display("FAIL ras_empty: got %0b want %0b", bus.ras_empty, m_ras.size() == 0);
         end
         n_chk++;
         if (bus.ras_full != (m_ras.size() == DEPTH)) begin
            n_err++;
            $display("FAIL ras_full: got %0b want %0b", bus.ras_full, m_ras.size() == DEPTH);
         end
         n_chk++;
         if (bus.ras_ovf != m_ovf) begin
            n_err++;
            $display("FAIL ras_ovf: got %0b want %0b", bus.ras_ovf, m_ovf);
         end
         n_chk++;
         if (bus.ras_unf != m_unf) begin
            n_err++;
            $display("FAIL ras_unf: got %0b want %0b", bus.ras_unf, m_unf);
         end
         if (lit_seq != last_seq) begin
            last_seq = lit_seq;
            n_chk++;
            if (int'(bus.pc) != lit_pc || m_pc != lit_pc ||
                (fl & lit_fmask) != (lit_flags & lit_fmask)) begin
               n_err++;
               $display("FAIL %s: got pc %03h flags %04b model pc %03h, want pc %03h flags %04b mask %04b",
                        lit_name, bus.pc, fl[3:0], m_pc, lit_pc, lit_flags[3:0], lit_fmask[3:0]);
            end
         end
      end
   end

   task automatic cyc(input bit rn, input bit st, input op_t op,
                      input logic [OFF_W-1:0] off, input logic [PC_W-1:0] tgt);
      reset_n    = rn;
      bus.stall  = st;
      bus.op     = op;
      bus.offset = off;
      bus.target = tgt;
      @(posedge clk);
      #1;
   endtask

   task automatic go(input op_t op, input logic [PC_W-1:0] tgt);
      cyc(1'b1, 1'b0, op, '0, tgt);
   endtask

   // flags order: {empty, full, ovf, unf}
   task automatic expect_lit(input string nm, input int pcv, input int mask, input int flags);
      lit_name  = nm;
      lit_pc    = pcv;
      lit_fmask = mask;
      lit_flags = flags;
      lit_seq++;
      @(negedge clk);
   endtask

   initial begin
      cyc(1'b0, 1'b0, OP_SEQ, '0, '0);
      chk_en = 1;
      expect_lit("reset", 'h000, 4'b1111, 4'b1000);
      go(OP_SEQ, '0);
      expect_lit("seq1", 'h001, 0, 0);
      go(OP_SEQ, '0);
      go(OP_SEQ, '0);
      expect_lit("seq3", 'h003, 0, 0);
      cyc(1'b0, 1'b1, OP_JMP, '0, 11'h123);
      expect_lit("reset_over_stall", 'h000, 4'b1111, 4'b1000);

      go(OP_JMP, 11'h010);
      cyc(1'b1, 1'b0, OP_BR, 8'hF0, '0);
      expect_lit("br_neg", 'h000, 0, 0);
      cyc(1'b1, 1'b0, OP_BR, 8'h7F, '0);
      expect_lit("br_pos", 'h07F, 0, 0);
      go(OP_JMP, 11'h7FF);
      go(OP_SEQ, '0);
      expect_lit("seq_wrap", 'h000, 0, 0);

      go(OP_JMP, 11'h020);
      go(OP_CALL, 11'h100);
      expect_lit("call", 'h100, 4'b1000, 4'b0000);
      go(OP_RET, '0);
      expect_lit("ret", 'h021, 4'b1000, 4'b1000);

      go(OP_JMP, 11'h300);
      for (int i = 0; i < 5; i++)
         go(OP_CALL, 11'(32'h200 + 32'h10 * i));
      expect_lit("nest_full_ovf", 'h240, 4'b1110, 4'b0110);
      go(OP_RET, '0);
      expect_lit("ret1", 'h231, 0, 0);
      go(OP_RET, '0);
      expect_lit("ret2", 'h221, 0, 0);
      go(OP_RET, '0);
      expect_lit("ret3", 'h211, 0, 0);
      go(OP_RET, '0);
      expect_lit("ret4", 'h201, 4'b1000, 4'b1000);
      go(OP_RET, '0);
      expect_lit("ret_unf", 'h202, 4'b1111, 4'b1011);

      for (int i = 0; i < 3; i++)
         cyc(1'b1, 1'b1, OP_JMP, '0, 11'h055);
      expect_lit("stall_hold", 'h202, 4'b1111, 4'b1011);
      go(OP_JMP, 11'h055);
      expect_lit("stall_release", 'h055, 0, 0);

      go(OP_CALL, 11'h040);
      go(op_t'(3'd6), '0);
      expect_lit("reserved6", 'h041, 4'b1000, 4'b0000);
      go(OP_RET, '0);
      expect_lit("ret_after_rsv", 'h056, 4'b1000, 4'b1000);

      cyc(1'b0, 1'b0, OP_CALL, '0, 11'h3AA);
      expect_lit("reset_over_call", 'h000, 4'b1111, 4'b1000);

      for (int i = 0; i < 3000; i++) begin
         int r;
         op_t op;
         r = $urandom_range(0, 99);
         if (r < 25)      op = OP_CALL;
         else if (r < 50) op = OP_RET;
         else             op = op_t'($urandom_range(0, 7));
         cyc($urandom_range(0, 149) != 0, $urandom_range(0, 4) == 0, op,
             OFF_W'($urandom), PC_W'($urandom));
      end
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
